// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared types and constants for the hazard/forwarding controller.
package hazard_forward_ctrl_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_t;

    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_EX   = 3'd1,
        SRC_MEM  = 3'd2,
        SRC_LSU  = 3'd3,
        SRC_WB   = 3'd4
    } fwd_src_t;

    localparam int unsigned GPR_ZERO = 0;
    localparam int unsigned CSR_NONE = 0;

endpackage

// File: rtl/hazard_fwd_mux.sv
// Per-operand forward selector: youngest matching stage wins, a load that has
// no data yet yields no source at all.
module hazard_fwd_mux
    import hazard_forward_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_match_ex,
    input  logic            i_match_mem,
    input  logic            i_match_wb,
    input  logic            i_ex_load,
    input  logic            i_mem_load,
    input  logic            i_lsu_resp,
    input  logic [XLEN-1:0] i_ex_data,
    input  logic [XLEN-1:0] i_mem_data,
    input  logic [XLEN-1:0] i_lsu_data,
    input  logic [XLEN-1:0] i_wb_data,
    output logic            o_hazard,
    output fwd_src_t        o_src,
    output logic [XLEN-1:0] o_data
);

    always_comb begin
        o_src = SRC_NONE;
        if (i_match_ex) begin
            if (!i_ex_load) o_src = SRC_EX;
        end else if (i_match_mem) begin
            if (!i_mem_load)     o_src = SRC_MEM;
            else if (i_lsu_resp) o_src = SRC_LSU;
        end else if (i_match_wb) begin
            o_src = SRC_WB;
        end
    end

    always_comb begin
        o_data = '0;
        case (o_src)
            SRC_EX:  o_data = i_ex_data;
            SRC_MEM: o_data = i_mem_data;
            SRC_LSU: o_data = i_lsu_data;
            SRC_WB:  o_data = i_wb_data;
            default: o_data = '0;
        endcase
    end

    assign o_hazard = (o_src != SRC_NONE);

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Central stall/flush/forward controller for the IF/ID, ID/EX and EX/MEM registers.
// Define HAZARD_PERF_EN to add saturating load-use / MEM_WAIT / flush counters.
module hazard_forward_ctrl
    import hazard_forward_ctrl_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned GPR_AW = 5,
    parameter int unsigned CSR_AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [GPR_AW-1:0] id_rs1,
    input  logic [GPR_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [CSR_AW-1:0] id_csr_rs,
    input  logic [GPR_AW-1:0] ex_rd,
    input  logic              ex_write_gpr,
    input  logic              ex_mem_to_reg,
    input  logic [XLEN-1:0]   ex_result,
    input  logic [CSR_AW-1:0] ex_csr_rd,
    input  logic              ex_write_csr,
    input  logic [XLEN-1:0]   ex_csr_result,
    input  logic              ex_branch_taken,
    input  logic [GPR_AW-1:0] mem_rd,
    input  logic              mem_write_gpr,
    input  logic              mem_mem_to_reg,
    input  logic [XLEN-1:0]   mem_result,
    input  logic [CSR_AW-1:0] mem_csr_rd,
    input  logic              mem_write_csr,
    input  logic [XLEN-1:0]   mem_csr_result,
    input  logic              lsu_req_valid,
    input  logic              lsu_resp_valid,
    input  logic [XLEN-1:0]   lsu_rdata,
    input  logic [GPR_AW-1:0] wb_rd,
    input  logic              wb_write_gpr,
    input  logic [XLEN-1:0]   wb_data,
    input  logic [CSR_AW-1:0] wb_csr_rd,
    input  logic              wb_write_csr,
    input  logic [XLEN-1:0]   wb_csr_data,
    output logic              stall_if,
    output logic              stall_id,
    output logic              stall_ex,
    output logic              stall_mem,
    output logic              flush_id,
    output logic              flush_ex,
    output logic              fwd_rs1_hazard,
    output logic              fwd_rs2_hazard,
    output logic              fwd_csr_hazard,
    output logic [XLEN-1:0]   fwd_rs1_data,
    output logic [XLEN-1:0]   fwd_rs2_data,
    output logic [XLEN-1:0]   fwd_csr_data
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]       perf_lu_cnt,
    output logic [31:0]       perf_memwait_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);

    hz_state_t r_state;
    logic      r_flush_pend;

    logic w_ex_ok, w_mem_ok, w_wb_ok, w_ex_csr_ok, w_mem_csr_ok, w_wb_csr_ok;
    logic w_rs1_ex, w_rs1_mem, w_rs1_wb, w_rs2_ex, w_rs2_mem, w_rs2_wb;
    logic w_csr_ex, w_csr_mem, w_csr_wb;
    logic w_rs1_block, w_rs2_block, w_csr_block;
    fwd_src_t w_rs1_src, w_rs2_src, w_csr_src;
    logic w_wait, w_lu, w_flush;

    assign w_ex_ok      = ex_write_gpr  && (ex_rd  != GPR_AW'(GPR_ZERO));
    assign w_mem_ok     = mem_write_gpr && (mem_rd != GPR_AW'(GPR_ZERO));
    assign w_wb_ok      = wb_write_gpr  && (wb_rd  != GPR_AW'(GPR_ZERO));
    assign w_ex_csr_ok  = ex_write_csr  && (ex_csr_rd  != CSR_AW'(CSR_NONE));
    assign w_mem_csr_ok = mem_write_csr && (mem_csr_rd != CSR_AW'(CSR_NONE));
    assign w_wb_csr_ok  = wb_write_csr  && (wb_csr_rd  != CSR_AW'(CSR_NONE));

    assign w_rs1_ex  = id_use_rs1 && w_ex_ok  && (ex_rd  == id_rs1);
    assign w_rs1_mem = id_use_rs1 && w_mem_ok && (mem_rd == id_rs1);
    assign w_rs1_wb  = id_use_rs1 && w_wb_ok  && (wb_rd  == id_rs1);
    assign w_rs2_ex  = id_use_rs2 && w_ex_ok  && (ex_rd  == id_rs2);
    assign w_rs2_mem = id_use_rs2 && w_mem_ok && (mem_rd == id_rs2);
    assign w_rs2_wb  = id_use_rs2 && w_wb_ok  && (wb_rd  == id_rs2);
    assign w_csr_ex  = w_ex_csr_ok  && (ex_csr_rd  == id_csr_rs);
    assign w_csr_mem = w_mem_csr_ok && (mem_csr_rd == id_csr_rs);
    assign w_csr_wb  = w_wb_csr_ok  && (wb_csr_rd  == id_csr_rs);

    hazard_fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
        .i_match_ex (w_rs1_ex),      .i_match_mem(w_rs1_mem),      .i_match_wb(w_rs1_wb),
        .i_ex_load  (ex_mem_to_reg), .i_mem_load (mem_mem_to_reg), .i_lsu_resp(lsu_resp_valid),
        .i_ex_data  (ex_result),     .i_mem_data (mem_result),
        .i_lsu_data (lsu_rdata),     .i_wb_data  (wb_data),
        .o_hazard   (fwd_rs1_hazard), .o_src(w_rs1_src), .o_data(fwd_rs1_data)
    );

    hazard_fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
        .i_match_ex (w_rs2_ex),      .i_match_mem(w_rs2_mem),      .i_match_wb(w_rs2_wb),
        .i_ex_load  (ex_mem_to_reg), .i_mem_load (mem_mem_to_reg), .i_lsu_resp(lsu_resp_valid),
        .i_ex_data  (ex_result),     .i_mem_data (mem_result),
        .i_lsu_data (lsu_rdata),     .i_wb_data  (wb_data),
        .o_hazard   (fwd_rs2_hazard), .o_src(w_rs2_src), .o_data(fwd_rs2_data)
    );

    hazard_fwd_mux #(.XLEN(XLEN)) u_fwd_csr (
        .i_match_ex (w_csr_ex),      .i_match_mem(w_csr_mem),      .i_match_wb(w_csr_wb),
        .i_ex_load  (1'b0),          .i_mem_load (1'b0),           .i_lsu_resp(lsu_resp_valid),
        .i_ex_data  (ex_csr_result), .i_mem_data (mem_csr_result),
        .i_lsu_data (lsu_rdata),     .i_wb_data  (wb_csr_data),
        .o_hazard   (fwd_csr_hazard), .o_src(w_csr_src), .o_data(fwd_csr_data)
    );

    // A matching operand with no source means its producer is a load still in flight.
    assign w_rs1_block = (w_rs1_ex || w_rs1_mem || w_rs1_wb) && (w_rs1_src == SRC_NONE);
    assign w_rs2_block = (w_rs2_ex || w_rs2_mem || w_rs2_wb) && (w_rs2_src == SRC_NONE);
    assign w_csr_block = (w_csr_ex || w_csr_mem || w_csr_wb) && (w_csr_src == SRC_NONE);

    assign w_wait  = (r_state == MEM_WAIT);
    assign w_lu    = w_rs1_block || w_rs2_block || w_csr_block;
    assign w_flush = !w_wait && (r_flush_pend || ex_branch_taken);

    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        stall_mem = 1'b0;
        flush_id  = 1'b0;
        flush_ex  = 1'b0;
        if (!rst) begin
            if (w_wait) begin
                stall_if  = !lsu_resp_valid;
                stall_id  = !lsu_resp_valid;
                stall_ex  = !lsu_resp_valid;
                stall_mem = !lsu_resp_valid;
            end else begin
                stall_if = w_lu && !w_flush;
                stall_id = w_lu && !w_flush;
                flush_id = w_flush;
                flush_ex = w_flush || w_lu;
            end
        end
    end

    // The held branch is the frozen EX instruction, so it is latched only once.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= RUN;
            r_flush_pend <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    r_flush_pend <= 1'b0;
                    if (lsu_req_valid && !lsu_resp_valid) r_state <= MEM_WAIT;
                end
                MEM_WAIT: begin
                    if (ex_branch_taken && !r_flush_pend) r_flush_pend <= 1'b1;
                    if (lsu_resp_valid) r_state <= RUN;
                end
                default: r_state <= RUN;
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic w_lu_bubble;
    assign w_lu_bubble = !rst && !w_wait && w_lu && !w_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_lu_cnt      <= '0;
            perf_memwait_cnt <= '0;
            perf_flush_cnt   <= '0;
        end else begin
            if (w_lu_bubble && (perf_lu_cnt != '1))   perf_lu_cnt      <= perf_lu_cnt + 32'd1;
            if (w_wait && (perf_memwait_cnt != '1))   perf_memwait_cnt <= perf_memwait_cnt + 32'd1;
            if (flush_id && (perf_flush_cnt != '1))   perf_flush_cnt   <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed plus randomized check of hazard_forward_ctrl against a stage-walk reference model.
module tb_hazard_forward_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
    logic        id_use_rs1, id_use_rs2;
    logic [2:0]  id_csr_rs, ex_csr_rd, mem_csr_rd, wb_csr_rd;
    logic        ex_write_gpr, ex_mem_to_reg, ex_write_csr, ex_branch_taken;
    logic        mem_write_gpr, mem_mem_to_reg, mem_write_csr;
    logic        lsu_req_valid, lsu_resp_valid, wb_write_gpr, wb_write_csr;
    logic [31:0] ex_result, ex_csr_result, mem_result, mem_csr_result, lsu_rdata, wb_data, wb_csr_data;
    logic        stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex;
    logic        fwd_rs1_hazard, fwd_rs2_hazard, fwd_csr_hazard;
    logic [31:0] fwd_rs1_data, fwd_rs2_data, fwd_csr_data;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_lu_cnt, perf_memwait_cnt, perf_flush_cnt;
    int unsigned m_lu_cnt, m_mw_cnt, m_fl_cnt;
`endif

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;
    bit m_wait = 1'b0;
    bit m_pend = 1'b0;

    always #5 clk = ~clk;

    hazard_forward_ctrl #(.XLEN(32), .GPR_AW(5), .CSR_AW(3)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_csr_rs(id_csr_rs),
        .ex_rd(ex_rd), .ex_write_gpr(ex_write_gpr), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_result(ex_result), .ex_csr_rd(ex_csr_rd), .ex_write_csr(ex_write_csr),
        .ex_csr_result(ex_csr_result), .ex_branch_taken(ex_branch_taken),
        .mem_rd(mem_rd), .mem_write_gpr(mem_write_gpr), .mem_mem_to_reg(mem_mem_to_reg),
        .mem_result(mem_result), .mem_csr_rd(mem_csr_rd), .mem_write_csr(mem_write_csr),
        .mem_csr_result(mem_csr_result),
        .lsu_req_valid(lsu_req_valid), .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
        .wb_rd(wb_rd), .wb_write_gpr(wb_write_gpr), .wb_data(wb_data),
        .wb_csr_rd(wb_csr_rd), .wb_write_csr(wb_write_csr), .wb_csr_data(wb_csr_data),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
        .flush_id(flush_id), .flush_ex(flush_ex),
        .fwd_rs1_hazard(fwd_rs1_hazard), .fwd_rs2_hazard(fwd_rs2_hazard),
        .fwd_csr_hazard(fwd_csr_hazard),
        .fwd_rs1_data(fwd_rs1_data), .fwd_rs2_data(fwd_rs2_data), .fwd_csr_data(fwd_csr_data)
`ifdef HAZARD_PERF_EN
        ,
        .perf_lu_cnt(perf_lu_cnt), .perf_memwait_cnt(perf_memwait_cnt),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Walk stages youngest first; the first writer of the operand decides everything.
    function automatic void gpr_model(input logic [4:0] idx, input logic use_op,
                                      output bit hz, output bit blk, output logic [31:0] d);
        logic [4:0]  rd [3];
        bit          wr [3];
        bit          ld [3];
        logic [31:0] v  [3];
        bit          done;
        rd[0] = ex_rd;        rd[1] = mem_rd;         rd[2] = wb_rd;
        wr[0] = ex_write_gpr; wr[1] = mem_write_gpr;  wr[2] = wb_write_gpr;
        ld[0] = ex_mem_to_reg; ld[1] = mem_mem_to_reg; ld[2] = 1'b0;
        v[0]  = ex_result;    v[1]  = mem_result;     v[2]  = wb_data;
        hz = 1'b0; blk = 1'b0; d = '0; done = 1'b0;
        for (int s = 0; s < 3; s++) begin
            if (!done && use_op && wr[s] && rd[s] != 5'd0 && rd[s] == idx) begin
                done = 1'b1;
                if (ld[s] && !(s == 1 && lsu_resp_valid)) blk = 1'b1;
                else begin
                    hz = 1'b1;
                    d  = ld[s] ? lsu_rdata : v[s];
                end
            end
        end
    endfunction

    function automatic void csr_model(output bit hz, output logic [31:0] d);
        hz = 1'b1;
        if (ex_write_csr && ex_csr_rd != 3'd0 && ex_csr_rd == id_csr_rs)        d = ex_csr_result;
        else if (mem_write_csr && mem_csr_rd != 3'd0 && mem_csr_rd == id_csr_rs) d = mem_csr_result;
        else if (wb_write_csr && wb_csr_rd != 3'd0 && wb_csr_rd == id_csr_rs)    d = wb_csr_data;
        else begin hz = 1'b0; d = '0; end
    endfunction

    // Inputs are already applied; check outputs mid-cycle, then advance the model across the edge.
    task automatic cycle(input string tag);
        bit h1, b1, h2, b2, hc, lu, fl;
        logic [31:0] d1, d2, dc;
        bit e_sif, e_sex, e_fid, e_fex;
        #2;
        gpr_model(id_rs1, id_use_rs1, h1, b1, d1);
        gpr_model(id_rs2, id_use_rs2, h2, b2, d2);
        csr_model(hc, dc);
        lu = b1 | b2;
        fl = 1'b0; e_sif = 1'b0; e_sex = 1'b0; e_fid = 1'b0; e_fex = 1'b0;
        if (!rst) begin
            if (m_wait) begin
                e_sif = !lsu_resp_valid;
                e_sex = !lsu_resp_valid;
            end else begin
                fl    = m_pend | ex_branch_taken;
                e_sif = lu & !fl;
                e_fid = fl;
                e_fex = fl | lu;
            end
        end
        chk({tag, ".stall_if"},  stall_if,  e_sif);
        chk({tag, ".stall_id"},  stall_id,  e_sif);
        chk({tag, ".stall_ex"},  stall_ex,  e_sex);
        chk({tag, ".stall_mem"}, stall_mem, e_sex);
        chk({tag, ".flush_id"},  flush_id,  e_fid);
        chk({tag, ".flush_ex"},  flush_ex,  e_fex);
        chk({tag, ".rs1_hz"},    fwd_rs1_hazard, h1);
        chk({tag, ".rs2_hz"},    fwd_rs2_hazard, h2);
        chk({tag, ".csr_hz"},    fwd_csr_hazard, hc);
        if (h1) chk({tag, ".rs1_data"}, fwd_rs1_data, d1);
        if (h2) chk({tag, ".rs2_data"}, fwd_rs2_data, d2);
        if (hc) chk({tag, ".csr_data"}, fwd_csr_data, dc);
        @(posedge clk);
`ifdef HAZARD_PERF_EN
        if (rst) begin
            m_lu_cnt = 0; m_mw_cnt = 0; m_fl_cnt = 0;
        end else begin
            if (!m_wait && lu && !fl) m_lu_cnt++;
            if (m_wait)               m_mw_cnt++;
            if (e_fid)                m_fl_cnt++;
        end
`endif
        if (rst) begin
            m_wait = 1'b0; m_pend = 1'b0;
        end else if (m_wait) begin
            if (ex_branch_taken) m_pend = 1'b1;
            if (lsu_resp_valid)  m_wait = 1'b0;
        end else begin
            m_pend = 1'b0;
            if (lsu_req_valid && !lsu_resp_valid) m_wait = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_csr_rs = '0;
        ex_rd = '0; ex_write_gpr = 1'b0; ex_mem_to_reg = 1'b0; ex_result = '0;
        ex_csr_rd = '0; ex_write_csr = 1'b0; ex_csr_result = '0; ex_branch_taken = 1'b0;
        mem_rd = '0; mem_write_gpr = 1'b0; mem_mem_to_reg = 1'b0; mem_result = '0;
        mem_csr_rd = '0; mem_write_csr = 1'b0; mem_csr_result = '0;
        lsu_req_valid = 1'b0; lsu_resp_valid = 1'b0; lsu_rdata = '0;
        wb_rd = '0; wb_write_gpr = 1'b0; wb_data = '0;
        wb_csr_rd = '0; wb_write_csr = 1'b0; wb_csr_data = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        @(posedge clk); #1;
        cycle("reset0");
        cycle("reset1");
        rst = 1'b0;
        cycle("post_reset");

        // ALU dependency: EX beats MEM, x0 never forwards
        ex_write_gpr = 1'b1; ex_rd = 5'd5; ex_result = 32'h11;
        mem_write_gpr = 1'b1; mem_rd = 5'd5; mem_result = 32'h22;
        id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        #1; chk("tp.alu_data", fwd_rs1_data, 32'h11);
        cycle("alu_dep");
        id_rs1 = 5'd0;
        cycle("alu_x0");

        // load-use then LSU forward
        idle();
        ex_write_gpr = 1'b1; ex_mem_to_reg = 1'b1; ex_rd = 5'd7;
        id_rs2 = 5'd7; id_use_rs2 = 1'b1;
        #1; chk("tp.lu_flush_ex", flush_ex, 1'b1);
        cycle("load_use");
        idle();
        mem_write_gpr = 1'b1; mem_mem_to_reg = 1'b1; mem_rd = 5'd7;
        lsu_resp_valid = 1'b1; lsu_rdata = 32'hDEAD;
        id_rs2 = 5'd7; id_use_rs2 = 1'b1;
        #1; chk("tp.lsu_data", fwd_rs2_data, 32'hDEAD);
        cycle("lsu_fwd");

        // four-cycle LSU wait, then zero-latency response
        idle();
        lsu_req_valid = 1'b1;
        cycle("lsu_req");
        lsu_req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1; chk("tp.wait_stall_mem", stall_mem, 1'b1);
            cycle("lsu_wait");
        end
        lsu_resp_valid = 1'b1;
        cycle("lsu_resp");
        lsu_resp_valid = 1'b0;
        cycle("after_resp");
        lsu_req_valid = 1'b1; lsu_resp_valid = 1'b1;
        cycle("zero_lat");
        idle();
        cycle("zero_lat_next");

        // branch while frozen: flush held until the cycle after exit
        lsu_req_valid = 1'b1;
        cycle("pend_req");
        lsu_req_valid = 1'b0; ex_branch_taken = 1'b1;
        cycle("pend_br0");
        cycle("pend_br1");
        lsu_resp_valid = 1'b1;
        cycle("pend_resp");
        idle();
        #1; chk("tp.pend_flush_id", flush_id, 1'b1);
        cycle("pend_flush");
        cycle("pend_done");

        // branch together with load-use
        ex_write_gpr = 1'b1; ex_mem_to_reg = 1'b1; ex_rd = 5'd7;
        id_rs2 = 5'd7; id_use_rs2 = 1'b1; ex_branch_taken = 1'b1;
        #1; chk("tp.br_lu_stall_if", stall_if, 1'b0);
        cycle("br_lu");

        // reset while waiting with a held flush
        idle();
        lsu_req_valid = 1'b1;
        cycle("rw_req");
        lsu_req_valid = 1'b0; ex_branch_taken = 1'b1;
        cycle("rw_br");
        rst = 1'b1;
        cycle("rw_rst");
        rst = 1'b0; idle();
        #1; chk("tp.rw_flush_id", flush_id, 1'b0);
`ifdef HAZARD_PERF_EN
        chk("tp.perf_lu_zero", perf_lu_cnt, 32'd0);
        chk("tp.perf_mw_zero", perf_memwait_cnt, 32'd0);
        chk("tp.perf_fl_zero", perf_flush_cnt, 32'd0);
`endif
        cycle("rw_after");

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            id_rs1 = 5'($urandom_range(0, 3)); id_use_rs1 = 1'($urandom);
            id_rs2 = 5'($urandom_range(0, 3)); id_use_rs2 = 1'($urandom);
            id_csr_rs = 3'($urandom_range(0, 2));
            ex_rd = 5'($urandom_range(0, 3)); ex_mem_to_reg = ($urandom_range(0, 2) == 0);
            ex_write_gpr = ex_mem_to_reg | 1'($urandom); ex_result = $urandom;
            ex_csr_rd = 3'($urandom_range(0, 2)); ex_csr_result = $urandom;
            ex_write_csr = !ex_mem_to_reg && 1'($urandom);
            ex_branch_taken = ($urandom_range(0, 4) == 0);
            mem_rd = 5'($urandom_range(0, 3)); mem_mem_to_reg = ($urandom_range(0, 2) == 0);
            mem_write_gpr = mem_mem_to_reg | 1'($urandom); mem_result = $urandom;
            mem_csr_rd = 3'($urandom_range(0, 2)); mem_csr_result = $urandom;
            mem_write_csr = !mem_mem_to_reg && 1'($urandom);
            lsu_req_valid = ($urandom_range(0, 3) == 0);
            lsu_resp_valid = ($urandom_range(0, 2) == 0); lsu_rdata = $urandom;
            wb_rd = 5'($urandom_range(0, 3)); wb_write_gpr = 1'($urandom); wb_data = $urandom;
            wb_csr_rd = 3'($urandom_range(0, 2)); wb_write_csr = 1'($urandom);
            wb_csr_data = $urandom;
            cycle("rand");
        end

`ifdef HAZARD_PERF_EN
        chk("perf_lu", perf_lu_cnt, m_lu_cnt);
        chk("perf_mw", perf_memwait_cnt, m_mw_cnt);
        chk("perf_fl", perf_flush_cnt, m_fl_cnt);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
